// File: rtl/regfile_seq_pkg.sv
// Shared types and instruction field layout for the register-file sequencer.
package regfile_seq_pkg;

    typedef enum logic [3:0] {
        OP_MOV = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_AND = 4'h3,
        OP_OR  = 4'h4,
        OP_XOR = 4'h5,
        OP_SHL = 4'h6,
        OP_SHR = 4'h7,
        OP_LDI = 4'h8,
        OP_MUL = 4'h9
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_e;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS0_MSB = 8;
    localparam int RS0_LSB = 6;
    localparam int RS1_MSB = 5;
    localparam int RS1_LSB = 3;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] ILLEGAL_OP_MIN = 4'hA;

endpackage

// File: rtl/regfile_seq_mul.sv
// Shift-add multiplier: loads on start_i, W iterations, done_o high during the last one.
// prod_o carries the finished product combinationally in that final cycle; no backpressure.
module regfile_seq_mul #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           done_o,
    output logic [2*W-1:0] prod_o
);

    localparam int CW = $clog2(W);

    logic [2*W-1:0] opa_q;
    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] acc_d;
    logic [W-1:0]   opb_q;
    logic [CW-1:0]  cnt_q;
    logic           run_q;

    assign acc_d  = acc_q + (opb_q[0] ? opa_q : '0);
    assign done_o = run_q && (cnt_q == CW'(W - 1));
    assign prod_o = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q <= '0;
            acc_q <= '0;
            opb_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            opa_q <= {{W{1'b0}}, a_i};
            opb_q <= b_i;
            acc_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            acc_q <= acc_d;
            opa_q <= opa_q << 1;
            opb_q <= opb_q >> 1;
            cnt_q <= cnt_q + 1'b1;
            if (done_o)
                run_q <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_sequencer.sv
// Register-file sequencer: accept -> read -> (mul exec) -> write-back; 3 cycles, MUL 19.
// Holds instr_ready low for the whole instruction, so one instruction is in flight at a time.
module regfile_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [ADDR_W-1:0] rd0_addr,
    output logic [ADDR_W-1:0] rd1_addr,
    input  logic [DATA_W-1:0] rd0_data,
    input  logic [DATA_W-1:0] rd1_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              flag_z,
    output logic              flag_c
);

    state_e              state_q;
    logic [3:0]          op_q;
    logic [ADDR_W-1:0]   rd_q;
    logic [7:0]          imm_q;
    logic [ADDR_W-1:0]   rd0_addr_q, rd1_addr_q, wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                wr_en_q, done_q, err_q, ready_q, busy_q;
    logic                flag_z_q, flag_c_q, pend_z_q, pend_c_q;

    logic [DATA_W-1:0]   alu_res;
    logic                alu_c;
    logic [DATA_W:0]     sum;
    logic                mul_start, mul_done;
    logic [2*DATA_W-1:0] mul_prod;
    logic                go_write, illegal;
    logic [DATA_W-1:0]   wb_res;
    logic                wb_c;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        sum     = {1'b0, rd0_data} + {1'b0, rd1_data};
        case (op_q)
            OP_MOV: alu_res = rd0_data;
            OP_ADD: begin
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
            end
            OP_SUB: begin
                alu_res = rd0_data - rd1_data;
                alu_c   = rd0_data < rd1_data;
            end
            OP_AND: alu_res = rd0_data & rd1_data;
            OP_OR:  alu_res = rd0_data | rd1_data;
            OP_XOR: alu_res = rd0_data ^ rd1_data;
            OP_SHL: alu_res = rd0_data << rd1_data[3:0];
            OP_SHR: alu_res = rd0_data >> rd1_data[3:0];
            OP_LDI: alu_res = DATA_W'(imm_q);
            default: ;
        endcase
    end

    assign mul_start = (state_q == READ) && (op_q == OP_MUL);

    regfile_seq_mul #(.W(DATA_W)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (mul_start),
        .a_i     (rd0_data),
        .b_i     (rd1_data),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );

    // Both the ALU path (from READ) and the multiplier (last EXEC cycle) load the same write-back registers.
    assign go_write = ((state_q == READ) && (op_q != OP_MUL)) || ((state_q == EXEC) && mul_done);
    assign illegal  = op_q >= ILLEGAL_OP_MIN;
    assign wb_res   = (state_q == EXEC) ? mul_prod[DATA_W-1:0] : alu_res;
    assign wb_c     = (state_q == EXEC) ? (|mul_prod[2*DATA_W-1:DATA_W]) : alu_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            imm_q      <= '0;
            rd0_addr_q <= '0;
            rd1_addr_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            flag_z_q   <= 1'b0;
            flag_c_q   <= 1'b0;
            pend_z_q   <= 1'b0;
            pend_c_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (instr_valid) begin
                        op_q       <= instr[OP_MSB:OP_LSB];
                        rd_q       <= instr[RD_MSB:RD_LSB];
                        imm_q      <= instr[IMM_MSB:IMM_LSB];
                        rd0_addr_q <= instr[RS0_MSB:RS0_LSB];
                        rd1_addr_q <= instr[RS1_MSB:RS1_LSB];
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= READ;
                    end
                end
                READ: state_q <= (op_q == OP_MUL) ? EXEC : WRITE;
                EXEC: if (mul_done) state_q <= WRITE;
                WRITE: begin
                    wr_en_q   <= 1'b0;
                    done_q    <= 1'b0;
                    err_q     <= 1'b0;
                    wr_data_q <= '0;
                    if (!err_q) begin
                        flag_z_q <= pend_z_q;
                        flag_c_q <= pend_c_q;
                    end
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            if (go_write) begin
                wr_en_q   <= !illegal;
                done_q    <= 1'b1;
                err_q     <= illegal;
                wr_addr_q <= rd_q;
                wr_data_q <= illegal ? '0 : wb_res;
                pend_z_q  <= (wb_res == '0);
                pend_c_q  <= wb_c;
            end
        end
    end

    assign instr_ready = ready_q;
    assign busy        = busy_q;
    assign rd0_addr    = rd0_addr_q;
    assign rd1_addr    = rd1_addr_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign done        = done_q;
    assign err         = err_q;
    assign flag_z      = flag_z_q;
    assign flag_c      = flag_c_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench: behavioural 8x16 register file around the sequencer, hand-computed results.
module tb_regfile_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic [2:0]  rd0_addr, rd1_addr, wr_addr;
    logic [15:0] rd0_data, rd1_data, wr_data;
    logic        wr_en, busy, done, err, flag_z, flag_c;

    logic [15:0] regs [8];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        watch_wr = 1'b0;
    logic        wr_seen  = 1'b0;

    always #5 clk = ~clk;

    regfile_sequencer #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rd0_addr    (rd0_addr),
        .rd1_addr    (rd1_addr),
        .rd0_data    (rd0_data),
        .rd1_data    (rd1_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .flag_z      (flag_z),
        .flag_c      (flag_c)
    );

    assign rd0_data = regs[rd0_addr];
    assign rd1_data = regs[rd1_addr];

    always @(posedge clk) begin
        if (wr_en)
            regs[wr_addr] <= wr_data;
        if (watch_wr && wr_en)
            wr_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs0, input logic [2:0] rs1);
        return {op, rd, rs0, rs1, 3'b000};
    endfunction

    function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
        return {4'h8, rd, 1'b0, imm};
    endfunction

    // Issue one instruction from IDLE; lat counts cycles after the accepting edge until done.
    task automatic run(input logic [15:0] iw, output int lat, output logic wen,
                       output logic [2:0] waddr, output logic [15:0] wdata,
                       output logic werr, output logic idle_seen);
        lat       = -1;
        wen       = 1'b0;
        waddr     = '0;
        wdata     = '0;
        werr      = 1'b0;
        idle_seen = 1'b0;
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = iw;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (!busy || instr_ready)
                idle_seen = 1'b1;
            if (done) begin
                lat   = n;
                wen   = wr_en;
                waddr = wr_addr;
                wdata = wr_data;
                werr  = err;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_quiet(input logic [15:0] iw);
        int l; logic e, r, i; logic [2:0] a; logic [15:0] d;
        run(iw, l, e, a, d, r, i);
        chk("setup_lat", l, (iw[15:12] == 4'h9) ? 18 : 2);
    endtask

    int          lat;
    logic        wen, werr, idle_seen;
    logic [2:0]  waddr;
    logic [15:0] wdata;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", instr_ready, 1);
        chk("rst_busy",  busy, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_done",  done, 0);
        chk("rst_err",   err, 0);
        chk("rst_flags", {flag_z, flag_c}, 0);

        // LDI r1,0x34
        run(ldi(3'd1, 8'h34), lat, wen, waddr, wdata, werr, idle_seen);
        chk("ldi_lat",   lat, 2);
        chk("ldi_wen",   wen, 1);
        chk("ldi_waddr", waddr, 1);
        chk("ldi_wdata", wdata, 16'h0034);
        chk("ldi_ready_low", idle_seen, 0);
        chk("ldi_flag_z", flag_z, 0);
        chk("ldi_reg", regs[1], 16'h0034);

        // Carry/zero chain
        run_quiet(ldi(3'd1, 8'hFF));
        run_quiet(ldi(3'd3, 8'd8));
        run(enc(4'h6, 3'd2, 3'd1, 3'd3), lat, wen, waddr, wdata, werr, idle_seen);
        chk("shl_wdata", wdata, 16'hFF00);
        run(enc(4'h4, 3'd2, 3'd2, 3'd1), lat, wen, waddr, wdata, werr, idle_seen);
        chk("or_wdata", wdata, 16'hFFFF);
        run_quiet(ldi(3'd4, 8'd1));
        run(enc(4'h1, 3'd5, 3'd2, 3'd4), lat, wen, waddr, wdata, werr, idle_seen);
        chk("add_wdata", wdata, 16'h0000);
        chk("add_waddr", waddr, 5);
        chk("add_flag_z", flag_z, 1);
        chk("add_flag_c", flag_c, 1);

        // SUB borrow
        run_quiet(ldi(3'd1, 8'd3));
        run_quiet(ldi(3'd2, 8'd5));
        run(enc(4'h2, 3'd3, 3'd1, 3'd2), lat, wen, waddr, wdata, werr, idle_seen);
        chk("sub_wdata", wdata, 16'hFFFE);
        chk("sub_flag_c", flag_c, 1);
        chk("sub_flag_z", flag_z, 0);

        // MUL 0x12 * 0x0D
        run_quiet(ldi(3'd1, 8'h12));
        run_quiet(ldi(3'd2, 8'h0D));
        run(enc(4'h9, 3'd3, 3'd1, 3'd2), lat, wen, waddr, wdata, werr, idle_seen);
        chk("mul_lat",   lat, 18);
        chk("mul_wdata", wdata, 16'h00EA);
        chk("mul_busy",  idle_seen, 0);
        chk("mul_flag_c", flag_c, 0);
        chk("mul_flag_z", flag_z, 0);
        chk("mul_reg",   regs[3], 16'h00EA);

        // MUL 0xFF00 * 0x0100 overflows to zero
        run_quiet(ldi(3'd1, 8'hFF));
        run_quiet(ldi(3'd2, 8'd8));
        run_quiet(enc(4'h6, 3'd1, 3'd1, 3'd2));
        run_quiet(ldi(3'd2, 8'd1));
        run_quiet(ldi(3'd4, 8'd8));
        run_quiet(enc(4'h6, 3'd2, 3'd2, 3'd4));
        run(enc(4'h9, 3'd6, 3'd1, 3'd2), lat, wen, waddr, wdata, werr, idle_seen);
        chk("mul2_wdata", wdata, 16'h0000);
        chk("mul2_flag_c", flag_c, 1);
        chk("mul2_flag_z", flag_z, 1);

        // Illegal opcode
        run(enc(4'hB, 3'd3, 3'd1, 3'd2), lat, wen, waddr, wdata, werr, idle_seen);
        chk("ill_lat",   lat, 2);
        chk("ill_err",   werr, 1);
        chk("ill_wen",   wen, 0);
        chk("ill_flags", {flag_z, flag_c}, 2'b11);
        chk("ill_reg",   regs[3], 16'h00EA);

        // Reset in the middle of a MUL
        @(negedge clk);
        watch_wr    = 1'b1;
        instr_valid = 1'b1;
        instr       = enc(4'h9, 3'd3, 3'd1, 3'd1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("mid_rst_wen", wr_en, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("mid_rst_no_write", wr_seen, 0);
        chk("mid_rst_reg", regs[3], 16'h00EA);
        chk("mid_rst_ready", instr_ready, 1);
        chk("mid_rst_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
